// File: rtl/hps2fpga_pkg.sv
// Shared constants and helpers for the HPS-to-FPGA write bridge.
// Readback path is controlled by the HPS2FPGA_READBACK_EN macro.
package hps2fpga_pkg;

    localparam logic [1:0] ADDR_PUSH   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_SHADOW = 2'd3;

    localparam int STAT_EMPTY       = 8;
    localparam int STAT_FULL        = 9;
    localparam int STAT_PUSHCNT_LSB = 16;
    localparam int CTRL_FLUSH_BIT   = 0;

    typedef struct packed {
        logic push;
        logic pop;
        logic flush;
    } fifo_ctl_t;

    // Bytes with byteenable set come from the bus, the rest from the previous word.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] wdata,
        input logic [31:0] prev,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = prev;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end else begin
                res[8*i +: 8] = prev[8*i +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] status_word(
        input logic [7:0]  cnt,
        input logic        empty,
        input logic        full,
        input logic [15:0] pushcnt
    );
        logic [31:0] s;
        s                                = 32'h0000_0000;
        s[7:0]                           = cnt;
        s[STAT_EMPTY]                    = empty;
        s[STAT_FULL]                     = full;
        s[STAT_PUSHCNT_LSB +: 16]        = pushcnt;
        return s;
    endfunction

endpackage

// File: rtl/hps2fpga_fifo.sv
// Synchronous FIFO with registered storage; head word is mem[rd_ptr], no fall-through.
// Flush clears pointers and count and takes priority over push/pop.
module hps2fpga_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign do_push_s = push_i && !full_o && !flush_i;
    assign do_pop_s  = pop_i && !empty_o && !flush_i;
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];

    // Next-state for pointers and fill count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clock) begin
        if (do_push_s && reset_n) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/hps2fpga.sv
// Avalon-MM write bridge: HPS writes are byte-merged, queued and streamed out on Q_export.
// Define HPS2FPGA_READBACK_EN to add the status/shadow read path and push counter.
module hps2fpga
    import hps2fpga_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [3:0]       byteenable,
    input  logic             read,
    output logic [31:0]      readdata,
    output logic             waitrequest,
    output logic [WIDTH-1:0] Q_export,
    output logic             q_valid,
    input  logic             q_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fifo_ctl_t   ctl_s;
    logic [31:0] merged_s;
    logic [31:0] shadow_q, shadow_d;
    logic [CW-1:0] count_s;
    logic        full_s;
    logic        empty_s;

    assign merged_s    = byte_merge(writedata, shadow_q, byteenable);
    assign waitrequest = write && (address == ADDR_PUSH) && full_s;
    assign q_valid     = !empty_s;

    // Avalon decode into FIFO controls; a stalled push simply does not happen.
    always_comb begin
        ctl_s.push  = 1'b0;
        ctl_s.pop   = 1'b0;
        ctl_s.flush = 1'b0;
        if (write && (address == ADDR_CTRL) && writedata[CTRL_FLUSH_BIT]) begin
            ctl_s.flush = 1'b1;
        end else begin
            ctl_s.push = write && (address == ADDR_PUSH) && !full_s;
            ctl_s.pop  = !empty_s && q_ready;
        end
    end

    // Shadow tracks the last accepted (merged) word.
    always_comb begin
        if (ctl_s.push) begin
            shadow_d = merged_s;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Shadow register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shadow_q <= 32'h0000_0000;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    hps2fpga_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (ctl_s.push),
        .pop_i   (ctl_s.pop),
        .flush_i (ctl_s.flush),
        .wdata_i (merged_s),
        .head_o  (Q_export),
        .count_o (count_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

`ifdef HPS2FPGA_READBACK_EN
    logic [15:0] pushcnt_q, pushcnt_d;
    logic [31:0] readdata_q, readdata_d;

    // Accepted-push counter, wraps at 65536 and survives a flush.
    always_comb begin
        if (ctl_s.push) begin
            pushcnt_d = pushcnt_q + 16'd1;
        end else begin
            pushcnt_d = pushcnt_q;
        end
    end

    // Read mux, sampled with the pre-edge state; held between reads.
    always_comb begin
        readdata_d = readdata_q;
        if (read) begin
            case (address)
                ADDR_STATUS: readdata_d = status_word(8'(count_s), empty_s, full_s, pushcnt_q);
                ADDR_SHADOW: readdata_d = shadow_q;
                default:     readdata_d = 32'h0000_0000;
            endcase
        end else begin
            readdata_d = readdata_q;
        end
    end

    // Readback registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pushcnt_q  <= 16'd0;
            readdata_q <= 32'h0000_0000;
        end else begin
            pushcnt_q  <= pushcnt_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
`else
    logic unused_rb_s;
    assign unused_rb_s = ^{read, count_s};
    assign readdata    = 32'h0000_0000;
`endif

endmodule
